// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller sharing one external hex decoder.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN also blanks leading zero digits (digit 0 always shows).
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter int GAP_CYCLES    = 8,
    parameter int AN_ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [4*NUM_DIGITS-1:0]   load_data,
    input  logic [NUM_DIGITS-1:0]     load_blank,
    output logic                      upd_done,
    output logic [3:0]                nibble_out,
    input  logic [6:0]                seg_in,
    output logic [6:0]                seg_out,
    output logic [NUM_DIGITS-1:0]     an_out
);

    localparam int CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(NUM_DIGITS);

    localparam logic ST_GAP  = 1'b0;
    localparam logic ST_SHOW = 1'b1;

    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic                    r_state;
    logic [CW-1:0]           r_cnt;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_active_data;
    logic [NUM_DIGITS-1:0]   r_active_blank;
    logic [4*NUM_DIGITS-1:0] r_shadow_data;
    logic [NUM_DIGITS-1:0]   r_shadow_blank;
    logic                    r_pending;
    logic                    r_upd_done;

    logic                    w_gap_end;
    logic                    w_show_end;
    logic                    w_commit;
    logic                    w_accept;
    logic [NUM_DIGITS-1:0]   w_lz;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic [NUM_DIGITS-1:0]   w_onehot;

    assign w_gap_end  = (r_state == ST_GAP)  && (r_cnt == GAP_LAST);
    assign w_show_end = (r_state == ST_SHOW) && (r_cnt == SHOW_LAST);
    // Commit only on the last digit's SHOW->GAP edge so a frame never mixes words.
    assign w_commit   = w_show_end && (r_idx == IDX_LAST) && r_pending;
    assign w_accept   = load_valid && !r_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_GAP;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_GAP: begin
                    if (w_gap_end) begin
                        r_state <= ST_SHOW;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    if (w_show_end) begin
                        r_state <= ST_GAP;
                        r_cnt   <= '0;
                        r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active_data  <= '0;
            r_active_blank <= '1;
            r_shadow_data  <= '0;
            r_shadow_blank <= '1;
            r_pending      <= 1'b0;
            r_upd_done     <= 1'b0;
        end else begin
            r_upd_done <= w_commit;
            if (w_commit) begin
                r_active_data  <= r_shadow_data;
                r_active_blank <= r_shadow_blank;
                r_pending      <= 1'b0;
            end else if (w_accept) begin
                r_shadow_data  <= load_data;
                r_shadow_blank <= load_blank;
                r_pending      <= 1'b1;
            end
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic w_zero_run;
    always_comb begin
        w_zero_run = 1'b1;
        w_lz       = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_zero_run = w_zero_run && (r_active_data[4*k +: 4] == 4'h0);
            w_lz[k]    = w_zero_run;
        end
    end
`else
    assign w_lz = '0;
`endif

    assign w_blank    = r_active_blank | w_lz;
    assign w_onehot   = (r_state == ST_SHOW) ? ({{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx) : '0;
    assign an_out     = (AN_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;
    assign nibble_out = r_active_data[4*r_idx +: 4];
    assign seg_out    = ((r_state == ST_SHOW) && !w_blank[r_idx]) ? seg_in : 7'h00;
    assign load_ready = ~r_pending;
    assign upd_done   = r_upd_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized scoreboard bench for seg7_scan_ctrl; reference model works from the frame timeline.
// Handshake: a word transfers on a rising edge where load_valid and load_ready are both high.
module tb_seg7_scan_ctrl;

    localparam int N    = 4;
    localparam int R    = 4;
    localparam int G    = 1;
    localparam int SLOT = G + R;
    localparam int P    = N * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = '0;
    logic [3:0]  load_blank = '0;
    logic        load_ready;
    logic        upd_done;
    logic [3:0]  nibble_out;
    logic [6:0]  seg_in;
    logic [6:0]  seg_out;
    logic [3:0]  an_out;

    int          m_k;
    logic        m_pend;
    logic        m_upd;
    logic [15:0] m_act_d;
    logic [15:0] m_sh_d;
    logic [3:0]  m_act_b;
    logic [3:0]  m_sh_b;

    logic [16:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    seg7_scan_ctrl #(
        .NUM_DIGITS(N), .REFRESH_DIV(R), .GAP_CYCLES(G), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_blank(load_blank), .upd_done(upd_done),
        .nibble_out(nibble_out), .seg_in(seg_in), .seg_out(seg_out), .an_out(an_out)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    assign seg_in = hex7(nibble_out);

    task automatic model_reset();
        m_k     = 0;
        m_pend  = 1'b0;
        m_upd   = 1'b0;
        m_act_d = '0;
        m_act_b = 4'hF;
        m_sh_d  = '0;
        m_sh_b  = 4'hF;
    endtask

    // Expected {ready, upd, an, seg, nibble} for the cycle numbered m_k since reset.
    function automatic logic [16:0] expect_now();
        int          slot;
        bit          show;
        bit          blank;
        logic [3:0]  nib;
        logic [3:0]  en;
        logic [6:0]  seg;
        slot  = (m_k / SLOT) % N;
        show  = (m_k % SLOT) >= G;
        nib   = 4'(m_act_d >> (4 * slot));
        blank = m_act_b[slot];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (slot > 0 && (m_act_d >> (4 * slot)) == 16'h0) blank = 1'b1;
`endif
        en  = show ? 4'(1 << slot) : 4'h0;
        seg = (show && !blank) ? hex7(nib) : 7'h00;
        return {!m_pend, m_upd, ~en, seg, nib};
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            logic pend_pre;
            pend_pre = m_pend;
            m_k      = m_k + 1;
            m_upd    = 1'b0;
            if ((m_k % P) == 0 && pend_pre) begin
                m_act_d = m_sh_d;
                m_act_b = m_sh_b;
                m_pend  = 1'b0;
                m_upd   = 1'b1;
            end
            if (load_valid && !pend_pre) begin
                m_sh_d = load_data;
                m_sh_b = load_blank;
                m_pend = 1'b1;
            end
        end
        exp_q.push_back(expect_now());
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [16:0] e;
            logic [16:0] a;
            e = exp_q.pop_front();
            a = {load_ready, upd_done, an_out, seg_out, nibble_out};
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL cycle_out t=%0t: got rdy=%b upd=%b an=%b seg=%h nib=%h, want rdy=%b upd=%b an=%b seg=%h nib=%h",
                         $time, a[16], a[15], a[14:11], a[10:4], a[3:0],
                         e[16], e[15], e[14:11], e[10:4], e[3:0]);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            load_data  = 16'($urandom);
            load_blank = 4'($urandom);
            @(negedge clk);
        end
    endtask

    // Called on a falling edge; holds the offer until a rising edge sees ready high.
    task automatic offer(input logic [15:0] d, input logic [3:0] b);
        logic rdy;
        bit   done;
        done       = 1'b0;
        load_valid = 1'b1;
        load_data  = d;
        load_blank = b;
        for (int t = 0; t < 200 && !done; t++) begin
            rdy = load_ready;
            @(negedge clk);
            if (rdy) done = 1'b1;
        end
        load_valid = 1'b0;
        load_data  = 16'($urandom);
        load_blank = 4'($urandom);
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL offer_timeout: word %h not accepted within 200 cycles", d);
        end
    endtask

    task automatic reset_mid_show();
        bit found;
        found = 1'b0;
        for (int t = 0; t < 100 && !found; t++) begin
            @(posedge clk);
            #2;
            if (m_pend && (m_k % SLOT) >= G) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL reset_window: no SHOW cycle with a pending word found");
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({load_ready, upd_done, an_out, seg_out} !== {1'b1, 1'b0, 4'hF, 7'h00}) begin
            n_err++;
            $display("FAIL async_reset: got rdy=%b upd=%b an=%b seg=%h, want rdy=1 upd=0 an=1111 seg=00",
                     load_ready, upd_done, an_out, seg_out);
        end
        model_reset();
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(40);
        idle(7);
        offer(16'h1234, 4'b0000);
        offer(16'hABCD, 4'b0000);
        idle(2 * P);
        offer(16'hFFFF, 4'b0101);
        idle(2 * P);
        for (int i = 0; i < 6; i++) begin
            offer(16'($urandom), 4'($urandom));
            idle($urandom_range(0, 30));
        end
        idle(2 * P);
        offer(16'($urandom), 4'b0000);
        reset_mid_show();
        idle(2 * P);
        offer(16'h0070, 4'b0000);
        idle(2 * P);
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
